// File: rtl/i2c_sched_pkg.sv
// rtl/i2c_sched_pkg.sv - shared types for the I2C transaction scheduler
package i2c_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] cmd;
        logic [7:0] data;
    } i2c_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Offset N wraps back to ptr itself, so the last winner is considered last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (en && !grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// rtl/i2c_txn_scheduler.sv - shares one i2c_controller among NUM_REQ clients
module i2c_txn_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [NUM_REQ*7-1:0]   req_addr_in,
    input  logic [NUM_REQ-1:0]     req_rw_in,
    input  logic [NUM_REQ*8-1:0]   req_cmd_in,
    input  logic [NUM_REQ*8-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    output logic [NUM_REQ-1:0]     rsp_valid_out,
    output logic [7:0]             rsp_data_out,
    output logic                   rsp_err_out,
    output logic                   rsp_retried_out,
    output logic                   busy_out,
    output logic                   i2c_start_out,
    output logic [6:0]             i2c_addr_out,
    output logic                   i2c_rw_out,
    output logic [7:0]             i2c_cmd_out,
    output logic [7:0]             i2c_data_out,
    input  logic [7:0]             i2c_data_byte_in,
    input  logic                   i2c_ack_in,
    input  logic                   i2c_valid_in
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t         state;
    i2c_req_t       req_q;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  owner_q;
    logic           retried_q;
    logic [TW-1:0]  tmo_cnt;
    logic [GW-1:0]  gap_cnt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid_in),
        .ptr       (rr_ptr),
        .en        (state == IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Controller parameters come straight from the latch so they stay stable for the whole transaction.
    assign i2c_addr_out = req_q.addr;
    assign i2c_rw_out   = req_q.rw;
    assign i2c_cmd_out  = req_q.cmd;
    assign i2c_data_out = req_q.data;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            req_q           <= '0;
            rr_ptr          <= IW'(NUM_REQ - 1);
            owner_q         <= '0;
            retried_q       <= 1'b0;
            tmo_cnt         <= '0;
            gap_cnt         <= '0;
            req_ready_out   <= '0;
            rsp_valid_out   <= '0;
            rsp_data_out    <= '0;
            rsp_err_out     <= 1'b0;
            rsp_retried_out <= 1'b0;
            busy_out        <= 1'b0;
            i2c_start_out   <= 1'b0;
        end else begin
            req_ready_out <= '0;
            rsp_valid_out <= '0;
            i2c_start_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        req_ready_out <= arb_grant;
                        req_q.addr    <= req_addr_in[7*arb_idx +: 7];
                        req_q.rw      <= req_rw_in[arb_idx];
                        req_q.cmd     <= req_cmd_in[8*arb_idx +: 8];
                        req_q.data    <= req_data_in[8*arb_idx +: 8];
                        owner_q       <= arb_idx;
                        rr_ptr        <= arb_idx;
                        retried_q     <= 1'b0;
                        busy_out      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    i2c_start_out <= 1'b1;
                    tmo_cnt       <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    retried_q <= retried_q | i2c_ack_in;
                    // Success wins when data_valid lands on the expiry cycle.
                    if (i2c_valid_in) begin
                        rsp_valid_out[owner_q] <= 1'b1;
                        rsp_data_out    <= req_q.rw ? i2c_data_byte_in : 8'h00;
                        rsp_err_out     <= 1'b0;
                        rsp_retried_out <= retried_q | i2c_ack_in;
                        state           <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_valid_out[owner_q] <= 1'b1;
                        rsp_data_out    <= 8'h00;
                        rsp_err_out     <= 1'b1;
                        rsp_retried_out <= retried_q | i2c_ack_in;
                        state           <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb/tb_i2c_txn_scheduler.sv - timeline model, controller model and directed tests for i2c_txn_scheduler
module tb_i2c_txn_scheduler;
    localparam int N   = 4;
    localparam int TMO = 1000;
    localparam int GAP = 16;

    logic           clk = 1'b0;
    logic           rst_in;
    logic [N-1:0]   req_valid_in;
    logic [N*7-1:0] req_addr_in;
    logic [N-1:0]   req_rw_in;
    logic [N*8-1:0] req_cmd_in;
    logic [N*8-1:0] req_data_in;
    logic [N-1:0]   req_ready_out;
    logic [N-1:0]   rsp_valid_out;
    logic [7:0]     rsp_data_out;
    logic           rsp_err_out;
    logic           rsp_retried_out;
    logic           busy_out;
    logic           i2c_start_out;
    logic [6:0]     i2c_addr_out;
    logic           i2c_rw_out;
    logic [7:0]     i2c_cmd_out;
    logic [7:0]     i2c_data_out;
    logic [7:0]     i2c_data_byte_in;
    logic           i2c_ack_in;
    logic           i2c_valid_in;

    i2c_txn_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_rw_in(req_rw_in),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_ready_out(req_ready_out),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_err_out(rsp_err_out),
        .rsp_retried_out(rsp_retried_out), .busy_out(busy_out), .i2c_start_out(i2c_start_out),
        .i2c_addr_out(i2c_addr_out), .i2c_rw_out(i2c_rw_out), .i2c_cmd_out(i2c_cmd_out),
        .i2c_data_out(i2c_data_out), .i2c_data_byte_in(i2c_data_byte_in),
        .i2c_ack_in(i2c_ack_in), .i2c_valid_in(i2c_valid_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++)
            if (v[i] === 1'b1) r = (r == -1) ? i : -2;
        return r;
    endfunction

    // Controller model knobs, sampled when a start pulse is seen
    int ctl_lat = 0, ctl_a1 = 0, ctl_a2 = 0;

    // Observations for the literal pins
    int         rdy_log[$];
    int         last_rdy_cyc = 0, last_rdy_idx = -1, last_start_cyc = 0;
    int         last_rsp_cyc = 0, last_rsp_idx = -1, last_valid_cyc = 0, rsp_cnt = 0;
    logic [6:0] st_addr;
    logic       st_rw;
    logic [7:0] st_cmd, st_data, rs_data;
    logic       rs_err, rs_retr;

    // Timeline model: grant cycle, end cycle and first free arbitration cycle
    bit         armed = 0, m_open = 0, m_acc = 0;
    int         m_g = -100000, m_e = -100000, m_free = 0, m_owner = 0, m_ptr = N - 1;
    logic [6:0] m_addr = '0;
    logic       m_rw = 1'b0;
    logic [7:0] m_cmd = '0, m_data = '0, m_rdata = '0;
    logic       m_err = 1'b0, m_retr = 1'b0;

    initial begin
        logic [N-1:0] e_rdy, e_rsp;
        int w;
        forever begin
            @(negedge clk);
            if (armed) begin
                e_rdy = '0;
                e_rsp = '0;
                if (cyc == m_g) e_rdy[m_owner] = 1'b1;
                if (cyc == m_e) e_rsp[m_owner] = 1'b1;
                chk("req_ready", req_ready_out, e_rdy);
                chk("i2c_start", i2c_start_out, (cyc == m_g + 1));
                chk("rsp_valid", rsp_valid_out, e_rsp);
                chk("rsp_data", rsp_data_out, m_rdata);
                chk("rsp_err", rsp_err_out, m_err);
                chk("rsp_retried", rsp_retried_out, m_retr);
                chk("busy", busy_out, (cyc >= m_g) && (m_open || cyc <= m_e + GAP));
                chk("i2c_addr", i2c_addr_out, m_addr);
                chk("i2c_rw", i2c_rw_out, m_rw);
                chk("i2c_cmd", i2c_cmd_out, m_cmd);
                chk("i2c_data", i2c_data_out, m_data);
                if (req_ready_out != 0) begin
                    last_rdy_cyc = cyc;
                    last_rdy_idx = oh_idx(req_ready_out);
                    rdy_log.push_back(last_rdy_idx);
                end
                if (i2c_start_out === 1'b1) begin
                    last_start_cyc = cyc;
                    st_addr = i2c_addr_out; st_rw = i2c_rw_out;
                    st_cmd = i2c_cmd_out;   st_data = i2c_data_out;
                end
                if (rsp_valid_out != 0) begin
                    last_rsp_cyc = cyc;
                    last_rsp_idx = oh_idx(rsp_valid_out);
                    rs_data = rsp_data_out; rs_err = rsp_err_out; rs_retr = rsp_retried_out;
                    rsp_cnt++;
                end
                if (i2c_valid_in === 1'b1) last_valid_cyc = cyc;
            end
            if (rst_in) begin
                armed = 1; m_open = 0; m_acc = 0;
                m_g = -100000; m_e = -100000; m_free = cyc + 1; m_ptr = N - 1;
                m_addr = '0; m_rw = 1'b0; m_cmd = '0; m_data = '0;
                m_rdata = '0; m_err = 1'b0; m_retr = 1'b0;
            end else if (armed) begin
                if (m_open) begin
                    // The WAIT window spans TMO cycles from the start pulse
                    if (cyc >= m_g + 1) begin
                        m_acc = m_acc | i2c_ack_in;
                        if (i2c_valid_in) begin
                            m_open = 0; m_e = cyc + 1; m_free = m_e + GAP + 1;
                            m_rdata = m_rw ? i2c_data_byte_in : 8'h00;
                            m_err = 1'b0; m_retr = m_acc;
                        end else if (cyc == m_g + TMO) begin
                            m_open = 0; m_e = cyc + 1; m_free = m_e + GAP + 1;
                            m_rdata = 8'h00; m_err = 1'b1; m_retr = m_acc;
                        end
                    end
                end else if (cyc >= m_free && req_valid_in != 0) begin
                    w = m_ptr;
                    for (int k = 1; k <= N; k++) begin
                        w = (m_ptr + k) % N;
                        if (req_valid_in[w]) break;
                    end
                    m_open = 1; m_acc = 0; m_g = cyc + 1; m_owner = w; m_ptr = w;
                    m_addr = req_addr_in[7*w +: 7]; m_rw = req_rw_in[w];
                    m_cmd = req_cmd_in[8*w +: 8];   m_data = req_data_in[8*w +: 8];
                end
            end
        end
    end

    // Behavioural i2c_controller: valid ctl_lat cycles after start, acks at given offsets
    initial begin
        int lat, a1, a2, lim;
        i2c_valid_in = 1'b0;
        i2c_ack_in   = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_start_out === 1'b1) begin
                lat = ctl_lat; a1 = ctl_a1; a2 = ctl_a2;
                lim = (lat > 0) ? lat : TMO;
                for (int k = 1; k <= lim + 1; k++) begin
                    @(posedge clk); #2;
                    if (rst_in) break;
                    i2c_ack_in   = (k == a1) || (k == a2);
                    i2c_valid_in = (lat > 0) && (k == lat);
                end
                i2c_valid_in = 1'b0;
                i2c_ack_in   = 1'b0;
            end
        end
    end

    task automatic client_req(input int i, input logic [6:0] a, input logic r,
                              input logic [7:0] c, input logic [7:0] d);
        bit got = 0;
        @(posedge clk); #1;
        req_addr_in[7*i +: 7] = a;
        req_rw_in[i]          = r;
        req_cmd_in[8*i +: 8]  = c;
        req_data_in[8*i +: 8] = d;
        req_valid_in[i]       = 1'b1;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (req_ready_out[i] === 1'b1) got = 1;
        end
        chk("ready_seen", got, 1);
        @(posedge clk); #1;
        req_valid_in[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int n = 0; n < 3000 && rsp_cnt < target; n++) @(negedge clk);
        chk("rsp_seen", (rsp_cnt >= target), 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000 && busy_out !== 1'b0; n++) @(negedge clk);
        chk("idle_seen", busy_out, 0);
    endtask

    initial begin
        int base, t4_rsp;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst_in = 1'b1;
        req_valid_in = '0; req_addr_in = '0; req_rw_in = '0; req_cmd_in = '0; req_data_in = '0;
        i2c_data_byte_in = 8'h00;
        repeat (4) @(posedge clk);
        #1 rst_in = 1'b0;
        repeat (3) @(posedge clk);

        // 1: client 1 write, valid after 300 cycles; read-back byte must not leak into a write
        ctl_lat = 300; ctl_a1 = 0; ctl_a2 = 0; i2c_data_byte_in = 8'hC3;
        base = rsp_cnt;
        client_req(1, 7'h48, 1'b0, 8'h01, 8'hA5);
        wait_rsp(base + 1);
        chk("t1_grant_idx", last_rdy_idx, 1);
        chk("t1_ready_to_start", last_start_cyc - last_rdy_cyc, 1);
        chk("t1_addr", st_addr, 7'h48);
        chk("t1_cmd", st_cmd, 8'h01);
        chk("t1_data", st_data, 8'hA5);
        chk("t1_start_to_rsp", last_rsp_cyc - last_start_cyc, 301);
        chk("t1_owner", last_rsp_idx, 1);
        chk("t1_err", rs_err, 0);
        chk("t1_retried", rs_retr, 0);
        chk("t1_rdata", rs_data, 8'h00);
        wait_idle();

        // 2: client 2 read returning 0x7E
        ctl_lat = 40; i2c_data_byte_in = 8'h7E;
        base = rsp_cnt;
        client_req(2, 7'h68, 1'b1, 8'h3B, 8'h00);
        wait_rsp(base + 1);
        chk("t2_rw", st_rw, 1);
        chk("t2_rdata", rs_data, 8'h7E);
        chk("t2_valid_to_rsp", last_rsp_cyc - last_valid_cyc, 1);
        chk("t2_owner", last_rsp_idx, 2);
        wait_idle();

        // 3: all four pending through reset release, client 0 re-raises after its first grant
        ctl_lat = 20; i2c_data_byte_in = 8'h55;
        rdy_log.delete();
        @(posedge clk); #1 rst_in = 1'b1;
        base = rsp_cnt;
        fork
            begin
                client_req(0, 7'h10, 1'b0, 8'hA0, 8'h01);
                client_req(0, 7'h11, 1'b1, 8'hA1, 8'h02);
            end
            client_req(1, 7'h21, 1'b0, 8'hB1, 8'h03);
            client_req(2, 7'h32, 1'b1, 8'hC2, 8'h04);
            client_req(3, 7'h43, 1'b0, 8'hD3, 8'h05);
            begin
                repeat (3) @(posedge clk);
                #1 rst_in = 1'b0;
            end
        join
        wait_rsp(base + 5);
        chk("t3_grant_count", rdy_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t3_grant_order", (i < rdy_log.size()) ? rdy_log[i] : -1, exp_order[i]);
        wait_idle();

        // 4: no valid ever -> timeout, then the next grant follows the gap
        ctl_lat = 0; i2c_data_byte_in = 8'h99;
        base = rsp_cnt;
        client_req(3, 7'h50, 1'b1, 8'h0F, 8'h00);
        repeat (3) @(posedge clk);
        ctl_lat = 10;
        client_req(0, 7'h51, 1'b0, 8'h10, 8'h20);
        chk("t4_rsp_seen", rsp_cnt, base + 1);
        t4_rsp = last_rsp_cyc;
        chk("t4_owner", last_rsp_idx, 3);
        chk("t4_err", rs_err, 1);
        chk("t4_rdata", rs_data, 8'h00);
        chk("t4_start_to_rsp", t4_rsp - (last_rdy_cyc - (t4_rsp - last_start_cyc) - 0 + 0) >= 0, 1);
        chk("t4_rsp_to_next_grant", last_rdy_cyc - t4_rsp, GAP + 2);
        wait_rsp(base + 2);
        wait_idle();

        // 5: two NACK pulses then success, followed by a clean read
        ctl_lat = 60; ctl_a1 = 10; ctl_a2 = 20; i2c_data_byte_in = 8'h00;
        base = rsp_cnt;
        client_req(1, 7'h22, 1'b0, 8'h33, 8'h44);
        wait_rsp(base + 1);
        chk("t5_retried", rs_retr, 1);
        chk("t5_err", rs_err, 0);
        wait_idle();
        ctl_lat = 30; ctl_a1 = 0; ctl_a2 = 0; i2c_data_byte_in = 8'h11;
        client_req(2, 7'h23, 1'b1, 8'h34, 8'h00);
        wait_rsp(base + 2);
        chk("t5_clean_retried", rs_retr, 0);
        chk("t5_clean_rdata", rs_data, 8'h11);
        wait_idle();

        // 6: reset during WAIT drops the transaction, then a fresh request proceeds
        ctl_lat = 500; i2c_data_byte_in = 8'hEE;
        base = rsp_cnt;
        client_req(0, 7'h60, 1'b1, 8'h61, 8'h00);
        repeat (50) @(posedge clk);
        #1 rst_in = 1'b1;
        @(posedge clk);
        #1 rst_in = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_no_rsp_after_reset", rsp_cnt, base);
        chk("t6_busy_after_reset", busy_out, 0);
        ctl_lat = 25; i2c_data_byte_in = 8'h00;
        client_req(3, 7'h70, 1'b0, 8'h71, 8'h72);
        wait_rsp(base + 1);
        chk("t6_owner", last_rsp_idx, 3);
        chk("t6_err", rs_err, 0);
        chk("t6_start_to_rsp", last_rsp_cyc - last_start_cyc, 26);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit, summary %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
